multicycle_control_unit: RTL and testbench

//  Multicycle MIPS control FSM. Sequences each instruction through fetch/decode/execute/writeback.

---
 rtl/multicycle_control_unit.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/writeback, drives datapath
// strobes and memory handshake, flags illegal instructions and counts retired ones.
// Optional jump support: define MC_CTRL_JUMP_EN.
module multicycle_control_unit #(
  parameter int unsigned ALU_W = 3,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             branch,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [ALU_W-1:0] alucontrol,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPEEX, S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MC_CTRL_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(3'b000);
  localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(3'b001);
  localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(3'b010);
  localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(3'b110);
  localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(3'b111);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;
  logic             w_rt_ok;
  logic [ALU_W-1:0] w_rt_alu;

  // R-type funct decode; also tells DECODE whether the funct is legal
  always_comb begin
    w_rt_ok  = 1'b1;
    w_rt_alu = ALU_AND;
    case (funct)
      6'b100000: w_rt_alu = ALU_ADD;
      6'b100010: w_rt_alu = ALU_SUB;
      6'b100100: w_rt_alu = ALU_AND;
      6'b100101: w_rt_alu = ALU_OR;
      6'b101010: w_rt_alu = ALU_SLT;
      default:   w_rt_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Next state and state-decoded outputs; everything held at 0 while reset is high
  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    mem_req    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = '0;
    illegal    = 1'b0;
    retired    = '0;
    if (reset) begin
      w_next = S_FETCH;
    end else begin
      retired = r_retired;
      case (r_state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alusrcb    = 2'b01;
          alucontrol = ALU_ADD;
          if (mem_ready) begin
            irwrite = 1'b1;
            pcwrite = 1'b1;
            w_next  = S_DECODE;
          end
        end
        S_DECODE: begin
          alusrcb    = 2'b11;
          alucontrol = ALU_ADD;
          case (opcode)
            OP_LW, OP_SW: w_next = S_MEMADR;
            OP_RTYPE: begin
              if (w_rt_ok) begin
                w_next = S_RTYPEEX;
              end else begin
                illegal = 1'b1;
                w_next  = S_FETCH;
              end
            end
            OP_BEQ:  w_next = S_BEQEX;
            OP_ADDI: w_next = S_ADDIEX;
`ifdef MC_CTRL_JUMP_EN
            OP_J:    w_next = S_JEX;
`endif
            default: begin
              illegal = 1'b1;
              w_next  = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          alucontrol = ALU_ADD;
          w_next     = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) w_next = S_MEMWB;
        end
        S_MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
        S_MEMWR: begin
          mem_req  = 1'b1;
          iord     = 1'b1;
          memwrite = 1'b1;
          if (mem_ready) begin
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
        end
        S_RTYPEEX: begin
          alusrca    = 1'b1;
          alucontrol = w_rt_alu;
          w_next     = S_RTYPEWB;
        end
        S_RTYPEWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
        S_BEQEX: begin
          alusrca    = 1'b1;
          alucontrol = ALU_SUB;
          branch     = 1'b1;
          pcsrc      = 2'b01;
          w_retire   = 1'b1;
          w_next     = S_FETCH;
        end
        S_ADDIEX: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          alucontrol = ALU_ADD;
          w_next     = S_ADDIWB;
        end
        S_ADDIWB: begin
          regwrite = 1'b1;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
`ifdef MC_CTRL_JUMP_EN
        S_JEX: begin
          pcwrite  = 1'b1;
          pcsrc    = 2'b10;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
`endif
        default: w_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed table-driven bench for multicycle_control_unit, plus a hand-written
// fetch-wait sequence. Honours MC_CTRL_JUMP_EN for the jump vectors.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        mem_ready;
  logic        mem_req, iord, memwrite, irwrite, pcwrite, branch;
  logic        regdst, memtoreg, regwrite, alusrca, illegal;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  alucontrol;
  logic [31:0] retired;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .pcwrite(pcwrite), .branch(branch), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .illegal(illegal), .retired(retired)
  );

  // Bundle order: mem_req iord memwrite irwrite pcwrite branch regdst memtoreg regwrite alusrca | alusrcb | pcsrc | alu | illegal
  logic [17:0] w_got;
  assign w_got = {mem_req, iord, memwrite, irwrite, pcwrite, branch, regdst, memtoreg,
                  regwrite, alusrca, alusrcb, pcsrc, alucontrol, illegal};

  localparam logic [17:0] ZERO    = 18'b0000000000_00_00_000_0;
  localparam logic [17:0] F_WAIT  = 18'b1000000000_01_00_010_0;
  localparam logic [17:0] F_GO    = 18'b1001100000_01_00_010_0;
  localparam logic [17:0] DEC     = 18'b0000000000_11_00_010_0;
  localparam logic [17:0] DEC_ILL = 18'b0000000000_11_00_010_1;
  localparam logic [17:0] MEMADR  = 18'b0000000001_10_00_010_0;
  localparam logic [17:0] MEMRD   = 18'b1100000000_00_00_000_0;
  localparam logic [17:0] MEMWB   = 18'b0000000110_00_00_000_0;
  localparam logic [17:0] MEMWR   = 18'b1110000000_00_00_000_0;
  localparam logic [17:0] RT_SUB  = 18'b0000000001_00_00_110_0;
  localparam logic [17:0] RT_SLT  = 18'b0000000001_00_00_111_0;
  localparam logic [17:0] RT_OR   = 18'b0000000001_00_00_001_0;
  localparam logic [17:0] RTWB    = 18'b0000001010_00_00_000_0;
  localparam logic [17:0] BEQ     = 18'b0000010001_00_01_110_0;
  localparam logic [17:0] ADDIEX  = 18'b0000000001_10_00_010_0;
  localparam logic [17:0] ADDIWB  = 18'b0000000010_00_00_000_0;
`ifdef MC_CTRL_JUMP_EN
  localparam logic [17:0] JEX     = 18'b0000100000_00_10_000_0;
`endif

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010, OP_BAD = 6'b111111;
  localparam logic [5:0] FN_SUB = 6'b100010, FN_SLT = 6'b101010, FN_OR = 6'b100101, FN_BAD = 6'b100111;

  typedef struct packed {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        rdy;
    logic [17:0] exp;
    logic [31:0] ret;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                     input logic rdy, input logic [17:0] exp, input logic [31:0] ret);
    vec_t v;
    v.rst = rst; v.op = op; v.fn = fn; v.rdy = rdy; v.exp = exp; v.ret = ret;
    tbl.push_back(v);
  endtask

  task automatic chk_out(input string name, input logic [17:0] exp);
    n_checks++;
    if (w_got !== exp) begin
      n_errors++;
      $display("FAIL %s outputs: got %b required %b", name, w_got, exp);
    end
  endtask

  task automatic chk_ret(input string name, input logic [31:0] exp);
    n_checks++;
    if (retired !== exp) begin
      n_errors++;
      $display("FAIL %s retired: got %0d required %0d", name, retired, exp);
    end
  endtask

  initial begin
    int cyc;
    bit found;
    reset = 1'b1; opcode = '0; funct = '0; mem_ready = 1'b0;

    // reset
    add(1, OP_R, FN_SUB, 0, ZERO, 0);
    add(1, OP_R, FN_SUB, 1, ZERO, 0);
    // lw with 3-cycle memory waits
    add(0, OP_LW, 0, 0, F_WAIT, 0);
    add(0, OP_LW, 0, 0, F_WAIT, 0);
    add(0, OP_LW, 0, 0, F_WAIT, 0);
    add(0, OP_LW, 0, 1, F_GO, 0);
    add(0, OP_LW, 0, 1, DEC, 0);
    add(0, OP_LW, 0, 1, MEMADR, 0);
    add(0, OP_LW, 0, 0, MEMRD, 0);
    add(0, OP_LW, 0, 0, MEMRD, 0);
    add(0, OP_LW, 0, 0, MEMRD, 0);
    add(0, OP_LW, 0, 1, MEMRD, 0);
    add(0, OP_LW, 0, 1, MEMWB, 0);
    // sub
    add(0, OP_R, FN_SUB, 1, F_GO, 1);
    add(0, OP_R, FN_SUB, 1, DEC, 1);
    add(0, OP_R, FN_SUB, 1, RT_SUB, 1);
    add(0, OP_R, FN_SUB, 1, RTWB, 1);
    // beq
    add(0, OP_BEQ, 0, 1, F_GO, 2);
    add(0, OP_BEQ, 0, 1, DEC, 2);
    add(0, OP_BEQ, 0, 1, BEQ, 2);
    // sw, one wait cycle
    add(0, OP_SW, 0, 1, F_GO, 3);
    add(0, OP_SW, 0, 0, DEC, 3);
    add(0, OP_SW, 0, 0, MEMADR, 3);
    add(0, OP_SW, 0, 0, MEMWR, 3);
    add(0, OP_SW, 0, 1, MEMWR, 3);
    // addi
    add(0, OP_ADDI, 0, 1, F_GO, 4);
    add(0, OP_ADDI, 0, 1, DEC, 4);
    add(0, OP_ADDI, 0, 1, ADDIEX, 4);
    add(0, OP_ADDI, 0, 1, ADDIWB, 4);
    // illegal opcode, illegal funct, then legal slt
    add(0, OP_BAD, 0, 1, F_GO, 5);
    add(0, OP_BAD, 0, 1, DEC_ILL, 5);
    add(0, OP_R, FN_BAD, 1, F_GO, 5);
    add(0, OP_R, FN_BAD, 1, DEC_ILL, 5);
    add(0, OP_R, FN_SLT, 1, F_GO, 5);
    add(0, OP_R, FN_SLT, 1, DEC, 5);
    add(0, OP_R, FN_SLT, 1, RT_SLT, 5);
    add(0, OP_R, FN_SLT, 1, RTWB, 5);
    // jump
    add(0, OP_J, 0, 1, F_GO, 6);
`ifdef MC_CTRL_JUMP_EN
    add(0, OP_J, 0, 1, DEC, 6);
    add(0, OP_J, 0, 1, JEX, 6);
    add(0, OP_LW, 0, 1, F_GO, 7);
`else
    add(0, OP_J, 0, 1, DEC_ILL, 6);
    add(0, OP_LW, 0, 1, F_GO, 6);
`endif
    // reset in the middle of a lw
    add(0, OP_LW, 0, 1, DEC, 0);
    tbl[$].ret = tbl[$-1].ret;
    add(0, OP_LW, 0, 1, MEMADR, tbl[$].ret);
    add(0, OP_LW, 0, 0, MEMRD, tbl[$].ret);
    add(1, OP_LW, 0, 1, ZERO, 0);
    add(1, OP_LW, 0, 1, ZERO, 0);
    add(0, OP_LW, 0, 0, F_WAIT, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rst; opcode = tbl[i].op; funct = tbl[i].fn; mem_ready = tbl[i].rdy;
      #1;
      chk_out($sformatf("row%0d", i), tbl[i].exp);
      chk_ret($sformatf("row%0d", i), tbl[i].ret);
    end

    // Hand sequence: "or" with a 5-cycle fetch wait, single irwrite pulse
    opcode = OP_R; funct = FN_OR;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 20) begin
      @(negedge clk);
      mem_ready = (cyc >= 5);
      #1;
      if (irwrite) found = 1'b1;
      else cyc++;
    end
    n_checks++;
    if (!found || cyc != 5) begin
      n_errors++;
      $display("FAIL fetch_wait: irwrite after %0d cycles (found=%0d) required 5", cyc, found);
    end
    @(negedge clk); mem_ready = 1'b1; #1; chk_out("or_decode", DEC);
    @(negedge clk); #1; chk_out("or_exec", RT_OR);
    @(negedge clk); #1; chk_out("or_wb", RTWB);
    @(negedge clk); mem_ready = 1'b0; #1; chk_out("or_fetch", F_WAIT);
    chk_ret("or_retired", 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
